div_iter: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.

---
 rtl/div_iter_pkg.sv | 23 ++
 rtl/div_iter.sv | 114 +++++++++++
 tb/tb_div_iter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/div_iter_pkg.sv
// Shared divider definitions: machine width and the E-stage ALU op codes
// that select DIV/DIVU, plus the decode helper that builds start_i.
package div_iter_pkg;

  localparam int XLEN = 32;

  typedef enum logic [4:0] {
    ALU_NOP  = 5'd0,
    ALU_ADD  = 5'd1,
    ALU_SUB  = 5'd2,
    ALU_DIV  = 5'd20,
    ALU_DIVU = 5'd21
  } alu_op_t;

  function automatic logic is_div_op(input alu_op_t op);
    return (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_signed_div(input alu_op_t op);
    return op == ALU_DIV;
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU; stalls F/D/E until {HI,LO} ready.
// Ports: clk, resetn, start_i, signed_i, annul_i, opdata1_i, opdata2_i,
//        div_stall_o, ready_o, result_o = {remainder, quotient}.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic               annul_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               div_stall_o,
  output logic               ready_o,
  output logic [2*WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    neg_a   = signed_i & opdata1_i[WIDTH-1];
    neg_b   = signed_i & opdata2_i[WIDTH-1];
    a_abs   = neg_a ? -opdata1_i : opdata1_i;
    b_abs   = neg_b ? -opdata2_i : opdata2_i;
    // Partial remainder picks up the next dividend bit, MSB first.
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    rem_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nxt = {quo[WIDTH-2:0], ~trial[WIDTH]};
    q_fix   = neg_q ? -quo_nxt : quo_nxt;
    r_fix   = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
    end else if (annul_i) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i) begin
            if (opdata2_i != '0) begin
              rem   <= '0;
              quo   <= a_abs;
              dvs   <= b_abs;
              neg_q <= neg_a ^ neg_b;
              neg_r <= neg_a;
              count <= '0;
              state <= BUSY;
            end else begin
              // Divide by zero: HI = dividend, LO = all ones.
              result_o <= {opdata1_i, {WIDTH{1'b1}}};
              state    <= DONE;
            end
          end
        end
        BUSY: begin
          rem   <= rem_nxt;
          quo   <= quo_nxt;
          count <= count + CW'(1);
          if (count == LAST) begin
            result_o <= {r_fix, q_fix};
            state    <= DONE;
          end
        end
        // start_i may still be high while the divide leaves E.
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o     = (state == DONE) & ~annul_i;
  assign div_stall_o = ~annul_i &
                       (((state == IDLE) & start_i) | (state == BUSY));

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed fix-up, div-by-zero,
// annul, back-to-back and reset behaviour.
module tb_div_iter;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        sgn;
  logic        annul;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        stall;
  logic        ready;
  logic [63:0] result;

  int n_chk;
  int n_fail;

  div_iter #(.WIDTH(32)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_i     (start),
    .signed_i    (sgn),
    .annul_i     (annul),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .div_stall_o (stall),
    .ready_o     (ready),
    .result_o    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one divide at a negedge, hold start through the ready cycle,
  // then drop it and confirm no restart.
  task automatic run_div(input string nm, input logic [31:0] a,
                         input logic [31:0] b, input logic s,
                         input logic [63:0] exp, input int lat);
    @(negedge clk);
    start = 1'b1;
    sgn   = s;
    op1   = a;
    op2   = b;
    for (int c = 1; c <= lat; c++) begin
      #1;
      n_chk++;
      if (stall !== (c < lat)) begin
        n_fail++;
        $display("FAIL %s stall cyc %0d: got %b want %b",
                 nm, c, stall, (c < lat));
      end
      n_chk++;
      if (ready !== (c == lat)) begin
        n_fail++;
        $display("FAIL %s ready cyc %0d: got %b want %b",
                 nm, c, ready, (c == lat));
      end
      if (c == lat) begin
        n_chk++;
        if (result !== exp) begin
          n_fail++;
          $display("FAIL %s result: got %h want %h", nm, result, exp);
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after-done: got stall=%b ready=%b want 0 0",
               nm, stall, ready);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    sgn    = 1'b0;
    annul  = 1'b0;
    op1    = '0;
    op2    = '0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (stall !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: got stall=%b ready=%b result=%h want 0 0 0",
               stall, ready, result);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_divu_basic();
    run_div("divu_100_7", 32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, 34);
    run_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0,
            {32'd0, 32'hFFFF_FFFF}, 34);
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    run_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1,
            {32'd1, 32'hFFFF_FFFD}, 34);
    run_div("divu_big", 32'hFFFF_FFF9, 32'd2, 1'b0,
            {32'd1, 32'h7FFF_FFFC}, 34);
  endtask

  task automatic test_overflow();
    run_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
            {32'd0, 32'h8000_0000}, 34);
  endtask

  task automatic test_div_zero();
    run_div("divu_zero", 32'd5, 32'd0, 1'b0, {32'd5, 32'hFFFF_FFFF}, 2);
  endtask

  task automatic test_annul();
    int seen;
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    op1   = 32'd100;
    op2   = 32'd7;
    repeat (10) @(negedge clk);
    annul = 1'b1;
    #1;
    n_chk++;
    if (stall !== 1'b0 || ready !== 1'b0) begin
      n_fail++;
      $display("FAIL annul same-cycle: got stall=%b ready=%b want 0 0",
               stall, ready);
    end
    @(negedge clk);
    annul = 1'b0;
    start = 1'b0;
    seen  = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (ready !== 1'b0 || stall !== 1'b0) seen++;
      @(negedge clk);
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL annul quiet: got %0d active cycles want 0", seen);
    end
    run_div("after_annul", 32'd9, 32'd3, 1'b0, {32'd0, 32'd3}, 34);
  endtask

  task automatic test_back_to_back();
    run_div("b2b_a", 32'd1000, 32'd10, 1'b0, {32'd0, 32'd100}, 34);
    run_div("b2b_b", 32'd1001, 32'd10, 1'b1, {32'd1, 32'd100}, 34);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    sgn   = 1'b0;
    op1   = 32'd1000;
    op2   = 32'd3;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    start  = 1'b0;
    @(negedge clk);
    #1;
    n_chk++;
    if (stall !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got stall=%b ready=%b result=%h want 0",
               stall, ready, result);
    end
    @(negedge clk);
    resetn = 1'b1;
    run_div("after_rst", 32'd1000, 32'd3, 1'b0, {32'd1, 32'd333}, 34);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_divu_basic();
    test_signed();
    test_overflow();
    test_div_zero();
    test_annul();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
